// File: rtl/c499_key_loader.sv
// ============================================================================
// Module      : c499_key_loader
// Description : Serial key loader for the locked c499 SEC core. It receives
//               the 13-bit key MSB first, followed by one even-parity bit, and
//               commits the key to registered p_key/x_key on a good frame.
//               Optional build macro: KEY_LOCK_ONCE_EN freezes the key after
//               the first successful commit, until rst.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module c499_key_loader #(
    parameter int P_W         = 4,
    parameter int X_W         = 9,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           key_start,
    input  logic           key_bit,
    input  logic           key_bit_vld,
    output logic           key_bit_rdy,
    output logic           key_busy,
    output logic           key_ok,
    output logic           key_err,
    output logic [P_W-1:0] p_key,
    output logic [X_W-1:0] x_key
);

    localparam int c_KEY_W  = P_W + X_W;
    localparam int c_CNT_W  = $clog2(c_KEY_W + 1);
    localparam int c_IDLE_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [c_CNT_W-1:0]  c_CNT_LAST  = c_CNT_W'(c_KEY_W);
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(TIMEOUT_CYC - 1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_SHIFT = 2'd1;
    localparam logic [1:0] c_S_CHECK = 2'd2;

    logic [1:0]          r_state;
    logic [c_KEY_W:0]    r_sr;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_IDLE_W-1:0] r_idle;
    logic                r_rdy;
    logic                r_busy;
    logic                r_ok;
    logic                r_err;
    logic [P_W-1:0]      r_p;
    logic [X_W-1:0]      r_x;

    logic w_beat;
    logic w_start;

    assign w_beat = key_bit_vld & r_rdy;

`ifdef KEY_LOCK_ONCE_EN
    logic r_locked;
    assign w_start = key_start & ~r_locked;
`else
    assign w_start = key_start;
`endif

    // Shift register holds data bits plus parity; a good frame XORs to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_idle  <= '0;
            r_rdy   <= 1'b0;
            r_busy  <= 1'b0;
            r_ok    <= 1'b0;
            r_err   <= 1'b0;
            r_p     <= '0;
            r_x     <= '0;
`ifdef KEY_LOCK_ONCE_EN
            r_locked <= 1'b0;
`endif
        end else if (w_start) begin
            r_state <= c_S_SHIFT;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_idle  <= '0;
            r_rdy   <= 1'b1;
            r_busy  <= 1'b1;
            r_ok    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    r_rdy  <= 1'b0;
                    r_busy <= 1'b0;
                end
                c_S_SHIFT: begin
                    if (w_beat) begin
                        r_sr   <= {r_sr[c_KEY_W-1:0], key_bit};
                        r_cnt  <= r_cnt + 1'b1;
                        r_idle <= '0;
                        if (r_cnt == c_CNT_LAST) begin
                            r_state <= c_S_CHECK;
                            r_rdy   <= 1'b0;
                        end
                    end else if (r_idle == c_IDLE_LAST) begin
                        r_state <= c_S_IDLE;
                        r_err   <= 1'b1;
                        r_rdy   <= 1'b0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_idle <= r_idle + 1'b1;
                    end
                end
                c_S_CHECK: begin
                    if (~^r_sr) begin
                        r_p  <= r_sr[c_KEY_W:X_W+1];
                        r_x  <= r_sr[X_W:1];
                        r_ok <= 1'b1;
`ifdef KEY_LOCK_ONCE_EN
                        r_locked <= 1'b1;
`endif
                    end else begin
                        r_err <= 1'b1;
                    end
                    r_state <= c_S_IDLE;
                    r_rdy   <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= c_S_IDLE;
                    r_rdy   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign key_bit_rdy = r_rdy;
    assign key_busy    = r_busy;
    assign key_ok      = r_ok;
    assign key_err     = r_err;
    assign p_key       = r_p;
    assign x_key       = r_x;

endmodule

`default_nettype wire

// File: tb/tb_c499_key_loader.sv
// ============================================================================
// Module      : tb_c499_key_loader
// Description : Directed self-checking bench for c499_key_loader with a
//               scoreboard of expected frame outcomes (KEY_LOCK_ONCE_EN aware).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_c499_key_loader;

    logic       clk;
    logic       rst;
    logic       key_start;
    logic       key_bit;
    logic       key_bit_vld;
    logic       key_bit_rdy;
    logic       key_busy;
    logic       key_ok;
    logic       key_err;
    logic [3:0] p_key;
    logic [8:0] x_key;

    typedef struct {
        string      tag;
        logic [3:0] p;
        logic [8:0] x;
        logic       ok;
        logic       err;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] m_p;
    logic [8:0] m_x;
    int         n_checks;
    int         n_err;

    c499_key_loader #(
        .P_W        (4),
        .X_W        (9),
        .TIMEOUT_CYC(64)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .key_start  (key_start),
        .key_bit    (key_bit),
        .key_bit_vld(key_bit_vld),
        .key_bit_rdy(key_bit_rdy),
        .key_busy   (key_busy),
        .key_ok     (key_ok),
        .key_err    (key_err),
        .p_key      (p_key),
        .x_key      (x_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
    endtask

    task automatic beat(input logic b, input int gap);
        repeat (gap) tick();
        key_bit     = b;
        key_bit_vld = 1'b1;
        tick();
        key_bit_vld = 1'b0;
    endtask

    // Bench model of a frame outcome, pushed when the frame is driven.
    task automatic push_frame(input string tag, input logic [12:0] k, input logic par);
        exp_t e;
        logic good;
        good = ~^{k, par};
        if (good) begin
            m_p = k[12:9];
            m_x = k[8:0];
        end
        e.tag = tag; e.p = m_p; e.x = m_x; e.ok = good; e.err = ~good;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({e.tag, "_p"},    p_key,    e.p);
        chk({e.tag, "_x"},    x_key,    e.x);
        chk({e.tag, "_ok"},   key_ok,   e.ok);
        chk({e.tag, "_err"},  key_err,  e.err);
        chk({e.tag, "_busy"}, key_busy, 1'b0);
    endtask

    task automatic send_frame(input string tag, input logic [12:0] k, input logic par, input int maxgap);
        push_frame(tag, k, par);
        for (int i = 12; i >= 0; i--)
            beat(k[i], (i == 12) ? 0 : $urandom_range(maxgap, 0));
        beat(par, $urandom_range(maxgap, 0));
        @(negedge clk);
        chk({tag, "_chk_busy"}, key_busy, 1'b1);
        chk({tag, "_chk_rdy"},  key_bit_rdy, 1'b0);
        chk({tag, "_chk_ok"},   key_ok, 1'b0);
        tick();
        pop_check();
    endtask

    initial begin
        n_checks    = 0;
        n_err       = 0;
        m_p         = '0;
        m_x         = '0;
        rst         = 1'b1;
        key_start   = 1'b0;
        key_bit     = 1'b0;
        key_bit_vld = 1'b0;
        tick();
        tick();
        chk("t1_p",    p_key, 4'h0);
        chk("t1_x",    x_key, 9'h000);
        chk("t1_ok",   key_ok, 1'b0);
        chk("t1_err",  key_err, 1'b0);
        chk("t1_busy", key_busy, 1'b0);
        chk("t1_rdy",  key_bit_rdy, 1'b0);
        rst = 1'b0;
        tick();

`ifdef KEY_LOCK_ONCE_EN
        start();
        send_frame("t6_bad", 13'h0F0F, 1'b1, 0);
        start();
        chk("t6_rdy_after_bad", key_bit_rdy, 1'b1);
        send_frame("t6_good", 13'h15A3, 1'b1, 0);
        chk("t6_good_p", p_key, 4'hA);
        chk("t6_good_x", x_key, 9'h1A3);
        push_frame("t6_lock", 13'h15A3, 1'b1);
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
        for (int i = 13; i >= 0; i--) begin
            key_bit     = (i == 0) ? 1'b1 : (i == 1);
            key_bit_vld = 1'b1;
            @(negedge clk);
            chk("t6_rdy_locked", key_bit_rdy, 1'b0);
            tick();
        end
        key_bit_vld = 1'b0;
        repeat (3) tick();
        pop_check();
`else
        start();
        @(negedge clk);
        chk("t2_rdy_shift", key_bit_rdy, 1'b1);
        chk("t2_busy_shift", key_busy, 1'b1);
        tick();
        send_frame("t2", 13'h15A3, 1'b1, 0);

        start();
        send_frame("t3", 13'h0F0F, 1'b1, 0);

        // Timeout: five bits then a silent line.
        start();
        for (int i = 0; i < 5; i++) beat(1'b1, 0);
        begin
            exp_t e;
            e.tag = "t4"; e.p = m_p; e.x = m_x; e.ok = 1'b0; e.err = 1'b1;
            sb.push_back(e);
        end
        repeat (63) tick();
        chk("t4_busy_pre", key_busy, 1'b1);
        chk("t4_err_pre",  key_err, 1'b0);
        tick();
        pop_check();

        // Restart mid-frame; the second start coincides with a dropped beat.
        start();
        for (int i = 0; i < 7; i++) beat(1'($urandom_range(1, 0)), 0);
        key_bit     = 1'b1;
        key_bit_vld = 1'b1;
        start();
        key_bit_vld = 1'b0;
        send_frame("t5", 13'h0001, 1'b1, 3);
        chk("t5_p", p_key, 4'h0);
        chk("t5_x", x_key, 9'h001);

        // Reset mid-frame zeroes the committed key.
        start();
        for (int i = 0; i < 3; i++) beat(1'b1, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_x",    x_key, 9'h000);
        chk("rst_mid_ok",   key_ok, 1'b0);
        chk("rst_mid_busy", key_busy, 1'b0);
        chk("rst_mid_rdy",  key_bit_rdy, 1'b0);
`endif

        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
